// File: rtl/i2c_slave_regs.sv
// I2C slave exposing sixteen 8-bit registers over a 4-bit auto-incrementing pointer, plus a host port.
// Latency: 2-FF sync plus one register from bus edges; host_rdata 1 cycle; wr_strobe follows the 8th data bit.
// Backpressure: none, scl is never stretched; host and I2C writes always complete, and I2C wins a same-register clash.
module i2c_slave_regs #(
    parameter logic [6:0] DEV_ADDR = 7'h68
) (
    input  logic       sys_clk_12m,
    input  logic       rst,
    input  logic       scl,
    inout  wire        sda,
    input  logic       host_we,
    input  logic [3:0] host_addr,
    input  logic [7:0] host_wdata,
    input  logic [3:0] host_raddr,
    output logic [7:0] host_rdata,
    output logic       wr_strobe,
    output logic [3:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy
);
    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE
    } state_t;

    state_t      state, state_nxt;
    logic [2:0]  scl_sr, sda_sr;
    logic        scl_rise, scl_fall, start_det, stop_det;
    logic [3:0]  bit_cnt;
    logic [7:0]  rx_sr, tx_sr;
    logic [3:0]  ptr;
    logic [7:0]  regs [16];
    logic        sda_drv, drv_nxt, busy_nxt, mack;
    logic        cnt_clr, rx_shift, i2c_we, ptr_load, ptr_inc, tx_load, tx_shift;
    logic [7:0]  i2c_wdata;

    assign sda = sda_drv ? 1'b0 : 1'bz;

    // [1] is the synchronized sample, [2] its previous value
    assign scl_rise  = scl_sr[1] & ~scl_sr[2];
    assign scl_fall  = ~scl_sr[1] & scl_sr[2];
    assign start_det = scl_sr[1] & scl_sr[2] & sda_sr[2] & ~sda_sr[1];
    assign stop_det  = scl_sr[1] & scl_sr[2] & ~sda_sr[2] & sda_sr[1];
    assign i2c_wdata = {rx_sr[6:0], sda_sr[1]};

    always_ff @(posedge sys_clk_12m) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        drv_nxt   = sda_drv;
        busy_nxt  = busy;
        cnt_clr   = 1'b0;
        rx_shift  = 1'b0;
        i2c_we    = 1'b0;
        ptr_load  = 1'b0;
        ptr_inc   = 1'b0;
        tx_load   = 1'b0;
        tx_shift  = 1'b0;
        if (stop_det) begin
            state_nxt = IDLE;
            drv_nxt   = 1'b0;
            busy_nxt  = 1'b0;
        end else if (start_det) begin
            state_nxt = ADDR;
            drv_nxt   = 1'b0;
            busy_nxt  = 1'b0;
            cnt_clr   = 1'b1;
        end else begin
            case (state)
                ADDR: begin
                    rx_shift = scl_rise;
                    if (scl_fall && bit_cnt == 4'd8) begin
                        cnt_clr = 1'b1;
                        if (rx_sr[7:1] == DEV_ADDR) begin
                            state_nxt = ADDR_ACK;
                            drv_nxt   = 1'b1;
                            busy_nxt  = 1'b1;
                        end else begin
                            state_nxt = IGNORE;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        cnt_clr = 1'b1;
                        // rx_sr[0] still holds the R/W bit: nothing shifts in this state
                        if (rx_sr[0]) begin
                            state_nxt = RD_BYTE;
                            tx_load   = 1'b1;
                            drv_nxt   = ~regs[ptr][7];
                        end else begin
                            state_nxt = PTR;
                            drv_nxt   = 1'b0;
                        end
                    end
                end
                PTR: begin
                    rx_shift = scl_rise;
                    if (scl_fall && bit_cnt == 4'd8) begin
                        cnt_clr   = 1'b1;
                        ptr_load  = 1'b1;
                        drv_nxt   = 1'b1;
                        state_nxt = PTR_ACK;
                    end
                end
                PTR_ACK, WR_ACK: begin
                    if (scl_fall) begin
                        cnt_clr   = 1'b1;
                        drv_nxt   = 1'b0;
                        state_nxt = WR_BYTE;
                    end
                end
                WR_BYTE: begin
                    rx_shift = scl_rise;
                    // commit on the 8th rising edge so a later STOP cannot lose a complete byte
                    if (scl_rise && bit_cnt == 4'd7) begin
                        i2c_we  = 1'b1;
                        ptr_inc = 1'b1;
                    end
                    if (scl_fall && bit_cnt == 4'd8) begin
                        cnt_clr   = 1'b1;
                        drv_nxt   = 1'b1;
                        state_nxt = WR_ACK;
                    end
                end
                RD_BYTE: begin
                    if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            cnt_clr   = 1'b1;
                            drv_nxt   = 1'b0;
                            ptr_inc   = 1'b1;
                            state_nxt = RD_ACK;
                        end else begin
                            tx_shift = 1'b1;
                            drv_nxt  = ~tx_sr[6];
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_fall) begin
                        cnt_clr = 1'b1;
                        if (mack) begin
                            state_nxt = RD_BYTE;
                            tx_load   = 1'b1;
                            drv_nxt   = ~regs[ptr][7];
                        end else begin
                            state_nxt = IGNORE;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk_12m) begin
        if (rst) begin
            scl_sr     <= 3'b111;
            sda_sr     <= 3'b111;
            sda_drv    <= 1'b0;
            busy       <= 1'b0;
            bit_cnt    <= 4'd0;
            rx_sr      <= 8'd0;
            tx_sr      <= 8'd0;
            ptr        <= 4'd0;
            mack       <= 1'b0;
            wr_strobe  <= 1'b0;
            wr_addr    <= 4'd0;
            wr_data    <= 8'd0;
            host_rdata <= 8'd0;
            for (int i = 0; i < 16; i++) begin
                regs[i] <= 8'd0;
            end
        end else begin
            scl_sr  <= {scl_sr[1:0], scl};
            sda_sr  <= {sda_sr[1:0], sda};
            sda_drv <= drv_nxt;
            busy    <= busy_nxt;
            if (cnt_clr) begin
                bit_cnt <= 4'd0;
            end else if (scl_rise && bit_cnt != 4'd15) begin
                bit_cnt <= bit_cnt + 4'd1;
            end
            if (rx_shift) begin
                rx_sr <= i2c_wdata;
            end
            if (tx_load) begin
                tx_sr <= regs[ptr];
            end else if (tx_shift) begin
                tx_sr <= {tx_sr[6:0], 1'b0};
            end
            if (state == RD_ACK && scl_rise) begin
                mack <= ~sda_sr[1];
            end
            if (ptr_load) begin
                ptr <= rx_sr[3:0];
            end else if (ptr_inc) begin
                ptr <= ptr + 4'd1;
            end
            if (host_we) begin
                regs[host_addr] <= host_wdata;
            end
            if (i2c_we) begin
                regs[ptr] <= i2c_wdata;
                wr_addr   <= ptr;
                wr_data   <= i2c_wdata;
            end
            wr_strobe  <= i2c_we;
            host_rdata <= regs[host_raddr];
        end
    end
endmodule

// File: tb/tb_i2c_slave_regs.sv
// Bench for i2c_slave_regs: bit-banged I2C master, transaction-level register model, per-cycle output compare.
`timescale 1ns/1ps
module tb_i2c_slave_regs;
    localparam int Q = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl = 1'b1;
    logic       m_low = 1'b0;
    logic       host_we = 1'b0;
    logic [3:0] host_addr = 4'd0;
    logic [7:0] host_wdata = 8'd0;
    logic [3:0] host_raddr = 4'd0;
    logic [7:0] host_rdata;
    logic       wr_strobe;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;
    wire        sda;

    assign sda = m_low ? 1'b0 : 1'bz;
    pullup (sda);

    always #42 clk = ~clk;

    i2c_slave_regs #(.DEV_ADDR(7'h68)) dut (
        .sys_clk_12m(clk),
        .rst(rst),
        .scl(scl),
        .sda(sda),
        .host_we(host_we),
        .host_addr(host_addr),
        .host_wdata(host_wdata),
        .host_raddr(host_raddr),
        .host_rdata(host_rdata),
        .wr_strobe(wr_strobe),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .busy(busy)
    );

    int          total = 0;
    int          bad = 0;
    logic [7:0]  m_regs [16];
    logic [3:0]  m_ptr = 4'd0;
    logic [11:0] exp_q [$];
    logic [11:0] exp_e;
    logic        quiet = 1'b0;
    logic [3:0]  last_wa = 4'd0;
    logic [7:0]  last_wd = 8'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // ---------------- model ----------------
    function automatic logic addr_ack(input logic [7:0] b);
        return b[7:1] == 7'h68;
    endfunction

    task automatic m_write(input logic [7:0] d);
        exp_q.push_back({m_ptr, d});
        m_regs[m_ptr] = d;
        m_ptr = m_ptr + 4'd1;
    endtask

    task automatic m_read(output logic [7:0] d);
        d = m_regs[m_ptr];
        m_ptr = m_ptr + 4'd1;
    endtask

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                if (wr_strobe) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL wr_strobe_unexpected: got addr=%0h data=%0h, want no strobe", wr_addr, wr_data);
                    end else begin
                        exp_e = exp_q.pop_front();
                        chk("wr_strobe_addr_data", 32'({wr_addr, wr_data}), 32'(exp_e));
                    end
                    last_wa = wr_addr;
                    last_wd = wr_data;
                end
                if (quiet && !m_low) begin
                    chk("sda_silent", 32'(sda), 32'd1);
                end
            end
        end
    end

    // ---------------- bus master ----------------
    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        m_low = 1'b0; wait_n(Q);
        scl = 1'b1;   wait_n(2*Q);
        m_low = 1'b1; wait_n(2*Q);
        scl = 1'b0;   wait_n(Q);
    endtask

    task automatic bus_stop();
        m_low = 1'b1; wait_n(Q);
        scl = 1'b1;   wait_n(2*Q);
        m_low = 1'b0; wait_n(2*Q);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            m_low = ~b[i]; wait_n(Q);
            scl = 1'b1;    wait_n(2*Q);
            scl = 1'b0;    wait_n(Q);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic exp_ack, input string name);
        logic ack;
        send_bits(b, 8);
        m_low = 1'b0; wait_n(Q);
        scl = 1'b1;   wait_n(Q);
        ack = (sda == 1'b0);
        wait_n(Q);
        scl = 1'b0;   wait_n(Q);
        chk(name, 32'(ack), 32'(exp_ack));
    endtask

    task automatic send_ptr(input logic [7:0] b, input string name);
        m_ptr = b[3:0];
        send_byte(b, 1'b1, name);
    endtask

    task automatic send_data(input logic [7:0] d, input string name);
        m_write(d);
        send_byte(d, 1'b1, name);
    endtask

    task automatic recv_byte(input logic nack, output logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            m_low = 1'b0; wait_n(Q);
            scl = 1'b1;   wait_n(Q);
            b[i] = sda;   wait_n(Q);
            scl = 1'b0;   wait_n(Q);
        end
        m_low = ~nack; wait_n(Q);
        scl = 1'b1;    wait_n(2*Q);
        scl = 1'b0;    wait_n(Q);
        m_low = 1'b0;
    endtask

    task automatic host_write(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        host_we = 1'b1; host_addr = a; host_wdata = d;
        m_regs[a] = d;
        @(negedge clk);
        host_we = 1'b0;
    endtask

    task automatic host_read(input logic [3:0] a, input string name);
        @(negedge clk);
        host_raddr = a;
        @(negedge clk);
        chk(name, 32'(host_rdata), 32'(m_regs[a]));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [7:0] rb;
        logic [7:0] e;
        for (int i = 0; i < 16; i++) m_regs[i] = 8'd0;

        wait_n(4);
        chk("rst_host_rdata", 32'(host_rdata), 32'd0);
        chk("rst_wr_strobe", 32'(wr_strobe), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sda", 32'(sda), 32'd1);
        rst = 1'b0;
        wait_n(4);

        // write burst: pointer 3, bytes A5 then 5A
        bus_start();
        send_byte(8'hD0, addr_ack(8'hD0), "w_addr_ack");
        chk("w_busy_after_match", 32'(busy), 32'd1);
        send_ptr(8'h03, "w_ptr_ack");
        send_data(8'hA5, "w_d0_ack");
        chk("w_strobe1_lit", 32'({last_wa, last_wd}), 32'h3A5);
        send_data(8'h5A, "w_d1_ack");
        chk("w_strobe2_lit", 32'({last_wa, last_wd}), 32'h45A);
        bus_stop();
        wait_n(4);
        chk("w_busy_after_stop", 32'(busy), 32'd0);
        host_read(4'd4, "w_rdata_model");
        chk("w_rdata_lit", 32'(host_rdata), 32'h5A);

        // read via repeated START: ACK then NACK
        host_write(4'd2, 8'h3C);
        host_write(4'd3, 8'hC3);
        bus_start();
        send_byte(8'hD0, addr_ack(8'hD0), "r_waddr_ack");
        send_ptr(8'h02, "r_ptr_ack");
        bus_start();
        send_byte(8'hD1, addr_ack(8'hD1), "r_raddr_ack");
        m_read(e);
        recv_byte(1'b0, rb);
        chk("r_byte0_model", 32'(rb), 32'(e));
        chk("r_byte0_lit", 32'(rb), 32'h3C);
        m_read(e);
        recv_byte(1'b1, rb);
        chk("r_byte1_model", 32'(rb), 32'(e));
        chk("r_byte1_lit", 32'(rb), 32'hC3);
        quiet = 1'b1;
        chk("r_busy_after_nack", 32'(busy), 32'd1);
        recv_byte(1'b1, rb);
        chk("r_released_after_nack", 32'(rb), 32'hFF);
        bus_stop();
        quiet = 1'b0;
        wait_n(4);
        chk("r_busy_after_stop", 32'(busy), 32'd0);

        // foreign address: never driven, no strobe, not busy
        quiet = 1'b1;
        bus_start();
        send_byte(8'hA0, addr_ack(8'hA0), "mm_addr_nack");
        chk("mm_busy", 32'(busy), 32'd0);
        send_byte(8'h00, 1'b0, "mm_data_nack");
        bus_stop();
        quiet = 1'b0;

        // pointer wrap 15 -> 0
        bus_start();
        send_byte(8'hD0, addr_ack(8'hD0), "wrap_addr_ack");
        send_ptr(8'h0F, "wrap_ptr_ack");
        send_data(8'h11, "wrap_d0_ack");
        send_data(8'h22, "wrap_d1_ack");
        bus_stop();
        host_read(4'd15, "wrap_reg15_model");
        chk("wrap_reg15_lit", 32'(host_rdata), 32'h11);
        host_read(4'd0, "wrap_reg0_model");
        chk("wrap_reg0_lit", 32'(host_rdata), 32'h22);
        chk("strobes_drained", 32'(exp_q.size()), 32'd0);

        // partial byte aborted by STOP, then read from the persisting pointer
        host_write(4'd7, 8'h99);
        bus_start();
        send_byte(8'hD0, addr_ack(8'hD0), "ab_addr_ack");
        send_ptr(8'h07, "ab_ptr_ack");
        send_bits(8'h00, 4);
        bus_stop();
        host_read(4'd7, "ab_reg7_model");
        chk("ab_reg7_lit", 32'(host_rdata), 32'h99);
        bus_start();
        send_byte(8'hD1, addr_ack(8'hD1), "ab_raddr_ack");
        m_read(e);
        recv_byte(1'b1, rb);
        chk("ab_read_model", 32'(rb), 32'(e));
        chk("ab_read_lit", 32'(rb), 32'h99);
        bus_stop();

        // reset while the slave is holding the address ACK low
        bus_start();
        send_bits(8'hD0, 8);
        m_low = 1'b0;
        wait_n(Q);
        chk("rs_ack_driven", 32'(sda), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 16; i++) m_regs[i] = 8'd0;
        m_ptr = 4'd0;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        chk("rs_sda_released", 32'(sda), 32'd1);
        quiet = 1'b1;
        scl = 1'b1; wait_n(2*Q);
        scl = 1'b0; wait_n(Q);
        chk("rs_busy", 32'(busy), 32'd0);
        bus_stop();
        quiet = 1'b0;
        host_read(4'd2, "rs_reg2_cleared");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
